// File: rtl/overlap_discard.sv
// overlap_discard: output stage of the overlap-save chain.
// Captures a 32-sample IFFT frame, drops the leading N_OVERLAP
// wrap-around samples and streams the kept tail one sample per enabled cycle.
module overlap_discard #(
  parameter int NB_DATA   = 16,
  parameter int N_OVERLAP = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_0,
  input  logic [NB_DATA-1:0] i_data_1,
  input  logic [NB_DATA-1:0] i_data_2,
  input  logic [NB_DATA-1:0] i_data_3,
  input  logic [NB_DATA-1:0] i_data_4,
  input  logic [NB_DATA-1:0] i_data_5,
  input  logic [NB_DATA-1:0] i_data_6,
  input  logic [NB_DATA-1:0] i_data_7,
  input  logic [NB_DATA-1:0] i_data_8,
  input  logic [NB_DATA-1:0] i_data_9,
  input  logic [NB_DATA-1:0] i_data_10,
  input  logic [NB_DATA-1:0] i_data_11,
  input  logic [NB_DATA-1:0] i_data_12,
  input  logic [NB_DATA-1:0] i_data_13,
  input  logic [NB_DATA-1:0] i_data_14,
  input  logic [NB_DATA-1:0] i_data_15,
  input  logic [NB_DATA-1:0] i_data_16,
  input  logic [NB_DATA-1:0] i_data_17,
  input  logic [NB_DATA-1:0] i_data_18,
  input  logic [NB_DATA-1:0] i_data_19,
  input  logic [NB_DATA-1:0] i_data_20,
  input  logic [NB_DATA-1:0] i_data_21,
  input  logic [NB_DATA-1:0] i_data_22,
  input  logic [NB_DATA-1:0] i_data_23,
  input  logic [NB_DATA-1:0] i_data_24,
  input  logic [NB_DATA-1:0] i_data_25,
  input  logic [NB_DATA-1:0] i_data_26,
  input  logic [NB_DATA-1:0] i_data_27,
  input  logic [NB_DATA-1:0] i_data_28,
  input  logic [NB_DATA-1:0] i_data_29,
  input  logic [NB_DATA-1:0] i_data_30,
  input  logic [NB_DATA-1:0] i_data_31,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_last,
  output logic               o_overflow
);

  localparam int N_KEEP = 32 - N_OVERLAP;
  localparam int CNT_W  = (N_KEEP > 1) ? $clog2(N_KEEP) : 1;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] bank_q [N_KEEP];
  logic [NB_DATA-1:0] bank_d [N_KEEP];
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               overflow_q, overflow_d;

  logic [NB_DATA-1:0] frame [32];
  logic [NB_DATA-1:0] unusedHead;
  logic               accept;

  assign frame[0]  = i_data_0;   assign frame[1]  = i_data_1;
  assign frame[2]  = i_data_2;   assign frame[3]  = i_data_3;
  assign frame[4]  = i_data_4;   assign frame[5]  = i_data_5;
  assign frame[6]  = i_data_6;   assign frame[7]  = i_data_7;
  assign frame[8]  = i_data_8;   assign frame[9]  = i_data_9;
  assign frame[10] = i_data_10;  assign frame[11] = i_data_11;
  assign frame[12] = i_data_12;  assign frame[13] = i_data_13;
  assign frame[14] = i_data_14;  assign frame[15] = i_data_15;
  assign frame[16] = i_data_16;  assign frame[17] = i_data_17;
  assign frame[18] = i_data_18;  assign frame[19] = i_data_19;
  assign frame[20] = i_data_20;  assign frame[21] = i_data_21;
  assign frame[22] = i_data_22;  assign frame[23] = i_data_23;
  assign frame[24] = i_data_24;  assign frame[25] = i_data_25;
  assign frame[26] = i_data_26;  assign frame[27] = i_data_27;
  assign frame[28] = i_data_28;  assign frame[29] = i_data_29;
  assign frame[30] = i_data_30;  assign frame[31] = i_data_31;

  // Ready while idle, or on the final beat so the next frame follows with no bubble.
  assign o_ready = i_enable & ((state_q == IDLE) | ((state_q == STREAM) & (cnt_q == '0)));
  assign accept  = i_valid & o_ready;

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_overflow = overflow_q;

  // Wrap-around head samples are never stored; fold them into a dead sink.
  always_comb begin
    unusedHead = '0;
    for (int j = 0; j < N_OVERLAP; j++) begin
      unusedHead = unusedHead ^ frame[j];
    end
  end

  // State and datapath registers; i_enable low freezes everything.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int j = 0; j < N_KEEP; j++) begin
        bank_q[j] <= '0;
      end
    end else if (i_enable) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      for (int j = 0; j < N_KEEP; j++) begin
        bank_q[j] <= bank_d[j];
      end
    end
  end

  // Next-state: accept starts a stream, an exhausted stream without a new frame goes idle.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = STREAM;
    end else if ((state_q == STREAM) && (cnt_q == '0)) begin
      state_d = IDLE;
    end
  end

  // Output/datapath next values: first kept sample goes straight to o_data,
  // the rest wait in the bank and shift down one slot per beat.
  always_comb begin
    cnt_d      = cnt_q;
    data_d     = '0;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    overflow_d = overflow_q | (i_valid & ~o_ready);
    for (int j = 0; j < N_KEEP; j++) begin
      bank_d[j] = bank_q[j];
    end

    if (accept) begin
      for (int j = 0; j < N_KEEP - 1; j++) begin
        bank_d[j] = frame[N_OVERLAP + 1 + j];
      end
      bank_d[N_KEEP-1] = '0;
      data_d  = frame[N_OVERLAP];
      valid_d = 1'b1;
      cnt_d   = CNT_W'(N_KEEP - 1);
      last_d  = (N_KEEP == 1);
    end else if ((state_q == STREAM) && (cnt_q != '0)) begin
      data_d = bank_q[0];
      for (int j = 0; j < N_KEEP - 1; j++) begin
        bank_d[j] = bank_q[j+1];
      end
      bank_d[N_KEEP-1] = '0;
      valid_d = 1'b1;
      cnt_d   = cnt_q - CNT_W'(1);
      last_d  = (cnt_q == CNT_W'(1));
    end
  end

endmodule

// File: doc/overlap_discard.md
# overlap_discard

Output stage of the overlap-save filtering chain. Captures a 32-sample frame delivered in parallel by the IFFT, discards the first N_OVERLAP samples (the circular-convolution wrap-around region), and streams the remaining 32 - N_OVERLAP valid samples serially, one per enabled cycle. Its sustained rate matches the overlap_save input framer: one new frame every 32 - N_OVERLAP cycles.

## Interface
- NB_DATA, 16: sample width in bits (packed complex, {I[15:8], Q[7:0]}); data passes through untouched.
- N_OVERLAP, 16: number of leading samples discarded per frame; legal range 1..31.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-low.
- i_enable  in  1  global clock enable; 0 freezes every register, including outputs.
- i_valid  in  1  frame strobe; i_data_0..31 hold a complete frame this cycle.
- i_data_0 .. i_data_31  in  NB_DATA each  parallel frame; index 0 is oldest in time.
- o_ready  out  1  combinational; 1 when a frame offered this cycle will be accepted.
- o_valid  out  1  registered; o_data holds a kept sample.
- o_data  out  NB_DATA  registered serial output sample.
- o_last  out  1  registered; high with the final kept sample of a frame.
- o_overflow  out  1  registered, sticky; set when a frame is offered while o_ready = 0.

## Operation
- N_KEEP = 32 - N_OVERLAP. Samples i_data_N_OVERLAP .. i_data_31 are kept and emitted in ascending index order; i_data_0 .. i_data_(N_OVERLAP-1) are never stored.
- FSM has two states: IDLE and STREAM. A down-counter cnt of width clog2(N_KEEP) tracks the remaining beats.
- o_ready = i_enable & (state == IDLE | (state == STREAM & cnt == 0)). A frame is therefore accepted back-to-back on the cycle its predecessor's last sample is emitted.
- Accept: when i_valid & o_ready, the N_KEEP kept samples are loaded into the shift bank. On the same edge, o_data receives i_data_N_OVERLAP, o_valid becomes 1, cnt becomes N_KEEP-1, and state becomes STREAM. o_last = 1 on this edge only when N_KEEP = 1.
- STREAM with i_enable = 1 and cnt > 0: the next kept sample is shifted to o_data, cnt decrements, o_valid stays 1, and o_last = 1 when the new cnt is 0.
- STREAM with cnt == 0 and no accept: the state returns to IDLE, and o_valid, o_last and o_data all become 0.
- IDLE with no accept: o_valid = 0, o_last = 0, o_data = 0.
- Drop: when i_valid & i_enable & !o_ready, the frame is discarded, o_overflow is set to 1, and the stream in progress continues unaffected. o_overflow clears only on reset.
- When i_enable = 0, i_valid is ignored. Offering a frame with i_enable = 0 does not set o_overflow.

## Timing
- Reset values: state = IDLE, cnt = 0, shift bank = 0, o_valid = 0, o_data = 0, o_last = 0, o_overflow = 0. o_ready becomes 1 as soon as i_enable = 1.
- Reset assertion mid-stream aborts the frame immediately and asynchronously; no partial samples appear after deassertion.
- Latency: a frame accepted at edge k presents its first kept sample after edge k. Its last kept sample appears after edge k + N_KEEP - 1.
- Throughput: one frame per N_KEEP enabled cycles with no bubbles, provided frames arrive exactly N_KEEP enabled cycles apart.
- Stall: i_enable low for m cycles stretches the stream by exactly m cycles, with outputs held constant during the stall.

## Test plan
- Reset then single frame: N_OVERLAP = 16, i_data_n = 16'h0100 + n, one i_valid pulse -> o_data runs 16'h0110 .. 16'h011F on 16 consecutive cycles starting the cycle after acceptance; o_last is high only with 16'h011F; o_valid then drops to 0.
- Back-to-back frames: frame A (n) followed by frame B (16'h0200 + n) offered exactly 16 cycles later -> 32 contiguous valid beats, 16'h0110 .. 16'h011F then 16'h0210 .. 16'h021F, with no gap; o_last pulses twice; o_overflow stays 0.
- Overflow: second frame offered 5 cycles after the first -> it is dropped, o_overflow = 1 and sticky, and the first frame's output sequence is intact.
- Stall: i_enable = 0 for 3 cycles while o_data = 16'h0114 -> 16'h0114 is held for those 3 cycles, 16'h0115 follows, and the total stream length is 19 cycles.
- Async reset mid-stream: i_rst = 0 while o_data = 16'h0118 -> o_valid, o_data and o_overflow go to 0 without waiting for a clock edge; after release, a new frame streams normally from its index 16.
- Parameter sweep: N_OVERLAP = 31 gives 1 beat per frame, with o_valid and o_last high together carrying i_data_31. N_OVERLAP = 8 gives 24 beats, i_data_8 .. i_data_31.
